izh_w_update_sched: RTL and testbench
=====================================

// Module: izh_w_update_sched
// PURPOSE
//  Time-multiplexes one shared recovery-variable datapath across NUM_NEURONS
//    Izhikevich neurons held in an external state RAM.
//  Datapath: dw = a*(b*v - w)*step, built from the team calc_dw instance.
//    The update w <- w + dw uses the team add module.
//  On start, sweeps indices 0..NUM_NEURONS-1: read (v,w), compute, write w back.
//  Sits between the network timestep controller and the neuron state RAM.
// PARAMETERS
//  N            18  total fixed-point width (signed two's complement)
//  Q            8   fractional bits
//  NUM_NEURONS  8   neurons per sweep (>=1)
//  IDX_W        3   index width, >= clog2(NUM_NEURONS), min 1
// PORTS
//  clk     in   1      clock, all logic on rising edge
//  reset   in   1      synchronous, active-high
//  start   in   1      sweep request; sampled only in IDLE
//  a       in   N      recovery rate; latched on accepted start
//  b       in   N      recovery sensitivity; latched on accepted start
//  step    in   N      integration timestep; latched on accepted start
//  rd_en   out  1      RAM read strobe
//  rd_idx  out  IDX_W  RAM read address
//  rd_v    in   N      v[rd_idx]; valid exactly 1 cycle after rd_en
//  rd_w    in   N      w[rd_idx]; valid exactly 1 cycle after rd_en
//  wr_en   out  1      RAM write strobe (w only; v untouched)
//  wr_idx  out  IDX_W  RAM write address
//  wr_w    out  N      updated w
//  busy    out  1      high in READ/WAIT/CALC/WRITE
//  done    out  1      one-cycle pulse at end of sweep
// BEHAVIOUR
//  Reset:
//    - state=IDLE; idx, a/b/step regs, v_r, w_r, dw_r <= 0.
//    - Outputs rd_en, wr_en, busy, done = 0; rd_idx, wr_idx, wr_w = 0.
//  FSM:
//    IDLE : start=1 -> latch a,b,step; idx<=0; go READ. Else stay.
//    READ : rd_en=1, rd_idx=idx -> WAIT.
//    WAIT : capture v_r<=rd_v, w_r<=rd_w -> CALC.
//    CALC : dw_r <= calc_dw(a_r,b_r,v_r,w_r,step_r), registered -> WRITE.
//    WRITE: wr_en=1, wr_idx=idx, wr_w=add(w_r,dw_r).
//           idx==NUM_NEURONS-1 -> DONE; else idx<=idx+1 -> READ.
//    DONE : done=1, busy=0 -> IDLE.
//  Timing:
//    - Start sampled in cycle 0.
//    - Neuron i is written in cycle 4+4i; done is high in cycle 4*NUM_NEURONS+1.
//    - Earliest next start is accepted in cycle 4*NUM_NEURONS+2.
//  Outputs are decoded from registered state/idx. rd_idx and wr_idx hold the
//    current idx whenever busy; strobes are 0 outside their states.
//  Arithmetic:
//    - Q-format is N bits, Q fractional, signed.
//    - Multiply, negate and add semantics (truncation/wrap) are exactly those
//      of the shared mult/negator/add modules; no extra saturation.
//  Boundaries:
//    - start while not IDLE (including DONE): ignored, not queued.
//    - a, b, step changing mid-sweep: no effect; latched copies are used.
//    - NUM_NEURONS=1: single pass, done in cycle 5.
//    - idx never exceeds NUM_NEURONS-1; there is no wrap.
//    - reset mid-sweep: returns to IDLE next edge; no further rd_en/wr_en.
//      A write already completed stays; the sweep is not resumed.
//    - reset and start asserted together: reset wins, start is dropped.
// TESTING
//  1. a=b=step=256 (1.0), v=512, w=128 -> wr_w=512 (2.0) at cycle 4.
//  2. a=128, b=64, step=128, v=1024, w=0 -> wr_w=64 (0.25).
//  3. a=b=step=256, v=-512, w=0 -> wr_w=18'h3FE00 (-2.0); checks sign path.
//  4. Full sweep, NUM_NEURONS=8, RAM model seeded v[i]=256*i, w=0, a=b=step=256
//     -> w[i]=256*i written at cycles 4+4i; done only at cycle 33; busy 1..32.
//  5. start pulsed at cycles 5 and 33, a changed at cycle 6 -> both ignored;
//     a single sweep runs with the original a.
//  6. reset at cycle 10 of a sweep -> neurons 0,1 written, none after;
//     all outputs 0 at cycle 11; a new start at cycle 12 runs a full sweep.

Source files
------------

// File: rtl/izh_w_update_sched.sv
// izh_w_update_sched: sweeps NUM_NEURONS Izhikevich neurons through one shared w-update datapath
module izh_w_update_sched #(
  parameter int N = 18,
  parameter int Q = 8,
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     step,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [N-1:0]     rd_v,
  input  logic [N-1:0]     rd_w,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [N-1:0]     wr_w,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, CALC, WRITE, DONE} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);
  state_t state, state_nx;
  logic [IDX_W-1:0] idx;
  logic signed [N-1:0] a_r, b_r, step_r, v_r, w_r, dw_r;
  function automatic logic signed [N-1:0] mul(input logic signed [N-1:0] x, input logic signed [N-1:0] y);
    logic signed [2*N-1:0] p;
    p = x * y;
    return p[Q +: N];
  endfunction
  // next-state decode; start is only honoured in IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? READ : IDLE;
      READ:    state_nx = WAIT;
      WAIT:    state_nx = CALC;
      CALC:    state_nx = WRITE;
      WRITE:   state_nx = (idx == LAST) ? DONE : READ;
      default: state_nx = IDLE;
    endcase
  end
  // state, index, latched coefficients and datapath pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      step_r <= '0;
      v_r    <= '0;
      w_r    <= '0;
      dw_r   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        a_r    <= a;
        b_r    <= b;
        step_r <= step;
        idx    <= '0;
      end
      if (state == WAIT) begin
        v_r <= rd_v;
        w_r <= rd_w;
      end
      if (state == CALC) dw_r <= mul(mul(a_r, mul(b_r, v_r) - w_r), step_r);
      if (state == WRITE && idx != LAST) idx <= idx + IDX_W'(1);
    end
  end
  assign busy   = state inside {READ, WAIT, CALC, WRITE};
  assign rd_en  = state == READ;
  assign wr_en  = state == WRITE;
  assign done   = state == DONE;
  assign rd_idx = busy ? idx : '0;
  assign wr_idx = busy ? idx : '0;
  assign wr_w   = wr_en ? w_r + dw_r : '0;
endmodule

// File: tb/tb_izh_w_update_sched.sv
// tb_izh_w_update_sched: vector, random and corner-case checks against an arithmetic reference model
module tb_izh_w_update_sched;
  localparam int N = 18, Q = 8, NN = 8;
  logic clk = 0, reset = 1, start = 0, start1 = 0;
  logic [N-1:0] a = 0, b = 0, step = 0;
  logic rd_en, wr_en, busy, done;
  logic [2:0] rd_idx, wr_idx;
  logic [N-1:0] rd_v = 0, rd_w = 0, wr_w;
  logic rd_en1, wr_en1, busy1, done1;
  logic [0:0] rd_idx1, wr_idx1;
  logic [N-1:0] v1 = 0, w1 = 0, wr_w1;
  logic [N-1:0] v_mem [NN];
  logic [N-1:0] w_mem [NN];
  int n_chk = 0, n_fail = 0, n_wr = 0;

  izh_w_update_sched #(.N(N), .Q(Q), .NUM_NEURONS(NN), .IDX_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .step(step),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_v(rd_v), .rd_w(rd_w),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_w(wr_w), .busy(busy), .done(done));

  izh_w_update_sched #(.N(N), .Q(Q), .NUM_NEURONS(1), .IDX_W(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a), .b(b), .step(step),
    .rd_en(rd_en1), .rd_idx(rd_idx1), .rd_v(v1), .rd_w(w1),
    .wr_en(wr_en1), .wr_idx(wr_idx1), .wr_w(wr_w1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_v <= v_mem[rd_idx];
      rd_w <= w_mem[rd_idx];
    end
    if (wr_en) begin
      w_mem[wr_idx] <= wr_w;
      n_wr <= n_wr + 1;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint sx(input logic [N-1:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint wrapn(input longint x);
    longint m = longint'(1) << N;
    longint y = x % m;
    if (y < 0) y += m;
    if (y >= m / 2) y -= m;
    return y;
  endfunction

  function automatic longint mulq(input longint x, input longint y);
    return wrapn((x * y) >>> Q);
  endfunction

  function automatic longint model(input longint ka, input longint kb, input longint ks, input longint kv, input longint kw);
    return wrapn(kw + mulq(mulq(ka, wrapn(mulq(kb, kv) - kw)), ks));
  endfunction

  task automatic run_sweep(input bit inject);
    longint exp_w [NN];
    for (int i = 0; i < NN; i++) exp_w[i] = model(sx(a), sx(b), sx(step), sx(v_mem[i]), sx(w_mem[i]));
    chk("idle_busy", busy, 0);
    start = 1;
    for (int k = 1; k <= 4 * NN + 3; k++) begin
      @(negedge clk);
      chk("busy", busy, (k <= 4 * NN) ? 1 : 0);
      chk("rd_en", rd_en, (k % 4 == 1 && k <= 4 * NN) ? 1 : 0);
      chk("wr_en", wr_en, (k % 4 == 0 && k <= 4 * NN) ? 1 : 0);
      chk("done", done, (k == 4 * NN + 1) ? 1 : 0);
      if (k % 4 == 1 && k <= 4 * NN) chk("rd_idx", rd_idx, (k - 1) / 4);
      if (k % 4 == 0 && k <= 4 * NN) begin
        chk("wr_idx", wr_idx, k / 4 - 1);
        chk("wr_w", sx(wr_w), exp_w[k / 4 - 1]);
      end
      start = inject && (k == 5 || k == 4 * NN + 1);
      if (inject && k == 6) a = N'($urandom);
    end
    for (int i = 0; i < NN; i++) chk("mem_w", sx(w_mem[i]), exp_w[i]);
  endtask

  typedef struct {longint a, b, s, v, w, exp;} vec_t;
  vec_t tbl [4];
  longint e0, e1;
  logic [N-1:0] w_orig [NN];
  int wr0;

  initial begin
    tbl[0] = '{256, 256, 256, 512, 128, 512};
    tbl[1] = '{128, 64, 128, 1024, 0, 64};
    tbl[2] = '{256, 256, 256, -512, 0, -512};
    tbl[3] = '{256, 512, 128, 256, 256, 384};
    for (int i = 0; i < NN; i++) begin
      v_mem[i] = 0;
      w_mem[i] = 0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_wr_w", wr_w, 0);
    chk("rst_busy1", busy1, 0);
    reset = 0;
    @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      a = N'(tbl[t].a);
      b = N'(tbl[t].b);
      step = N'(tbl[t].s);
      for (int i = 0; i < NN; i++) begin
        v_mem[i] = (i == 0) ? N'(tbl[t].v) : '0;
        w_mem[i] = (i == 0) ? N'(tbl[t].w) : '0;
      end
      run_sweep(0);
      chk("tbl_w", sx(w_mem[0]), tbl[t].exp);
    end
    a = 256;
    b = 256;
    step = 256;
    for (int i = 0; i < NN; i++) begin
      v_mem[i] = N'(256 * i);
      w_mem[i] = 0;
    end
    run_sweep(0);
    for (int i = 0; i < NN; i++) chk("ramp_w", sx(w_mem[i]), 256 * i);
    a = N'($urandom);
    b = N'($urandom);
    step = N'($urandom);
    for (int i = 0; i < NN; i++) begin
      v_mem[i] = N'($urandom);
      w_mem[i] = N'($urandom);
    end
    run_sweep(1);
    repeat (6) begin
      a = N'($urandom);
      b = N'($urandom);
      step = N'($urandom_range(0, 1023));
      for (int i = 0; i < NN; i++) begin
        v_mem[i] = N'($urandom);
        w_mem[i] = N'($urandom);
      end
      run_sweep(0);
    end
    a = N'($urandom);
    b = N'($urandom);
    step = N'($urandom);
    for (int i = 0; i < NN; i++) begin
      v_mem[i] = N'($urandom);
      w_mem[i] = N'($urandom);
      w_orig[i] = w_mem[i];
    end
    e0 = model(sx(a), sx(b), sx(step), sx(v_mem[0]), sx(w_mem[0]));
    e1 = model(sx(a), sx(b), sx(step), sx(v_mem[1]), sx(w_mem[1]));
    wr0 = n_wr;
    start = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 0;
      if (k == 10) begin
        reset = 1;
        start = 1;
      end
    end
    @(negedge clk);
    reset = 0;
    start = 0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rd_en", rd_en, 0);
    chk("rst_mid_wr_en", wr_en, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_wr_w", wr_w, 0);
    chk("rst_mid_nwr", n_wr - wr0, 2);
    chk("rst_mid_w0", sx(w_mem[0]), e0);
    chk("rst_mid_w1", sx(w_mem[1]), e1);
    for (int i = 2; i < NN; i++) chk("rst_mid_wkeep", w_mem[i], w_orig[i]);
    @(negedge clk);
    run_sweep(0);
    a = 256;
    b = 256;
    step = 256;
    v1 = 512;
    w1 = 128;
    start1 = 1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start1 = 0;
      chk("n1_busy", busy1, (k <= 4) ? 1 : 0);
      chk("n1_rd_en", rd_en1, (k == 1) ? 1 : 0);
      chk("n1_wr_en", wr_en1, (k == 4) ? 1 : 0);
      chk("n1_done", done1, (k == 5) ? 1 : 0);
      if (k == 4) begin
        chk("n1_wr_idx", wr_idx1, 0);
        chk("n1_wr_w", sx(wr_w1), 512);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
